// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative radix-2 restoring divider for RV32M DIV, DIVU,
//                REM and REMU. Sits in EX beside the ALU; busy stalls the
//                front end while iterating. The result is muxed with the
//                ALU result into EX/MEM.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      rising-edge clock
//    rst_n        in   1      asynchronous active-low reset
//    start        in   1      divide request, sampled only in IDLE
//    flush        in   1      abort operation in progress
//    operand_a    in   WIDTH  dividend (rs1)
//    operand_b    in   WIDTH  divisor  (rs2)
//    div_sel_div  in   1      signed quotient
//    div_sel_divu in   1      unsigned quotient
//    div_sel_rem  in   1      signed remainder
//    div_sel_remu in   1      unsigned remainder
//    busy         out  1      high in CALC and DONE (stall request)
//    done         out  1      one-cycle pulse, result valid
//    result       out  WIDTH  quotient or remainder, held until next start
//    zero_flag    out  1      result == 0
// ============================================================================
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             div_sel_div,
   input  logic             div_sel_divu,
   input  logic             div_sel_rem,
   input  logic             div_sel_remu,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag
);

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] C_ALL_ONE = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   rem_q;      // partial remainder
   logic [WIDTH-1:0]   quo_q;      // dividend shifting out, quotient in
   logic [WIDTH-1:0]   dvsr_q;     // divisor magnitude
   logic               neg_q_q;    // negate quotient at the end
   logic               neg_r_q;    // negate remainder at the end
   logic               is_rem_q;   // operation returns the remainder
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;

   // -------------------------------------------------------------------------
   // Operation decode (priority div > divu > rem > remu)
   // -------------------------------------------------------------------------
   logic               w_op_valid;
   logic               w_op_signed;
   logic               w_op_rem;

   always_comb begin
      w_op_valid  = 1'b1;
      w_op_signed = 1'b0;
      w_op_rem    = 1'b0;
      if (div_sel_div) begin
         w_op_signed = 1'b1;
      end else if (div_sel_divu) begin
         w_op_signed = 1'b0;
      end else if (div_sel_rem) begin
         w_op_signed = 1'b1;
         w_op_rem    = 1'b1;
      end else if (div_sel_remu) begin
         w_op_rem    = 1'b1;
      end else begin
         w_op_valid  = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Operand preparation and special-case detection at accept
   // -------------------------------------------------------------------------
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_div_zero;
   logic               w_overflow;
   logic               w_special;
   logic [WIDTH-1:0]   w_special_res;
   logic               w_accept;

   always_comb begin
      w_a_neg    = w_op_signed & operand_a[WIDTH-1];
      w_b_neg    = w_op_signed & operand_b[WIDTH-1];
      // Magnitude of the most negative value is itself when read unsigned,
      // which is exactly what the unsigned iteration needs.
      w_a_mag    = w_a_neg ? (~operand_a + 1'b1) : operand_a;
      w_b_mag    = w_b_neg ? (~operand_b + 1'b1) : operand_b;
      w_div_zero = (operand_b == '0);
      w_overflow = w_op_signed && (operand_a == C_MIN_NEG) && (operand_b == C_ALL_ONE);
      w_special  = w_div_zero | w_overflow;

      if (w_div_zero) begin
         w_special_res = w_op_rem ? operand_a : C_ALL_ONE;
      end else begin
         w_special_res = w_op_rem ? '0 : C_MIN_NEG;
      end

      // flush beats start; start without any select is ignored.
      w_accept = start & ~flush & w_op_valid;
   end

   // -------------------------------------------------------------------------
   // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
   // The compare uses WIDTH+1 bits so the bit shifted out of rem counts.
   // -------------------------------------------------------------------------
   logic [WIDTH:0]     w_rem_shift;
   logic               w_trial_ok;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;

   always_comb begin
      w_rem_shift = {rem_q, quo_q[WIDTH-1]};
      w_trial_ok  = (w_rem_shift >= {1'b0, dvsr_q});
      // When the trial succeeds the difference is below the divisor, so it
      // fits in WIDTH bits and the truncated subtraction is exact.
      rem_d       = w_trial_ok ? (w_rem_shift[WIDTH-1:0] - dvsr_q)
                               : w_rem_shift[WIDTH-1:0];
      quo_d       = {quo_q[WIDTH-2:0], w_trial_ok};
   end

   // -------------------------------------------------------------------------
   // Sign correction applied on the CALC -> DONE transition
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_final;

   always_comb begin
      w_quo_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
      w_rem_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;
      w_final   = is_rem_q ? w_rem_fix : w_quo_fix;
   end

   // -------------------------------------------------------------------------
   // Control FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         is_rem_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  is_rem_q <= w_op_rem;
                  busy_q   <= 1'b1;
                  if (w_special) begin
                     // Resolved immediately; no iteration needed.
                     result_q <= w_special_res;
                     zero_q   <= (w_special_res == '0);
                     done_q   <= 1'b1;
                     neg_q_q  <= 1'b0;
                     neg_r_q  <= 1'b0;
                     state_q  <= S_DONE;
                  end else begin
                     rem_q   <= '0;
                     quo_q   <= w_a_mag;
                     dvsr_q  <= w_b_mag;
                     neg_q_q <= w_a_neg ^ w_b_neg;
                     neg_r_q <= w_a_neg;
                     cnt_q   <= CNT_W'(WIDTH);
                     state_q <= S_CALC;
                  end
               end
            end

            S_CALC: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q == '0) begin
                  // All WIDTH steps are done; this cycle only finalises.
                  result_q <= w_final;
                  zero_q   <= (w_final == '0);
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_DONE: begin
               // Single-cycle state; flush leads to the same place.
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign zero_flag = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard bench for div_unit. The driver pushes expected
//                results from a plain-arithmetic RV32M model; a monitor pops
//                and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

   localparam int W = 32;
   localparam logic [3:0] SEL_DIV  = 4'b0001;
   localparam logic [3:0] SEL_DIVU = 4'b0010;
   localparam logic [3:0] SEL_REM  = 4'b0100;
   localparam logic [3:0] SEL_REMU = 4'b1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  operand_a = '0;
   logic [W-1:0]  operand_b = '0;
   logic [3:0]    sel = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          zero_flag;

   div_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .flush        (flush),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .div_sel_div  (sel[0]),
      .div_sel_divu (sel[1]),
      .div_sel_rem  (sel[2]),
      .div_sel_remu (sel[3]),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .zero_flag    (zero_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      int           t_acc;   // cycle count right after the accept edge
      int           delay;   // edges from accept edge to done cycle
   } exp_t;

   exp_t          sb_q[$];
   int            errors = 0;
   int            checks = 0;
   logic [W-1:0]  last_result = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: RV32M division semantics in plain arithmetic.
   function automatic logic [W-1:0] model(input logic [3:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, output int delay);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      logic                is_signed;
      logic                is_rem;
      sa = a;
      sb = b;
      is_signed = s[0] | (!s[1] & s[2]);
      is_rem    = !s[0] & !s[1] & (s[2] | s[3]);
      delay = W + 1;
      if (b == 0) begin
         delay = 0;
         return is_rem ? a : {W{1'b1}};
      end
      if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         delay = 0;
         return is_rem ? 32'h0 : 32'h8000_0000;
      end
      if (s[0])      return sa / sb;
      else if (s[1]) return a / b;
      else if (s[2]) return sa % sb;
      else           return a % b;
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h with nothing pending", result);
         end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("zero_flag", {31'b0, zero_flag}, {31'b0, (e.res == 0)});
            check("done_latency", cyc - e.t_acc, e.delay);
            check("busy_in_done", {31'b0, busy}, 32'd1);
            last_result = result;
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (!busy) return;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic launch(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
      logic [W-1:0] r;
      int           d;
      wait_idle();
      start     = 1'b1;
      sel       = s;
      operand_a = a;
      operand_b = b;
      if (push && s != 0) begin
         r = model(s, a, b, d);
         sb_q.push_back('{res: r, t_acc: cyc + 1, delay: d});
      end
      @(posedge clk);
      #2;
      start = 1'b0;
      sel   = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
      wait_idle();
   endtask

   logic [W-1:0] prior;
   logic [W-1:0] ra;
   logic [W-1:0] rb;
   logic [3:0]   rs;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero_flag", {31'b0, zero_flag}, 32'd1);
      rst_n = 1'b1;

      // Directed cases
      launch(SEL_DIVU, 32'd100, 32'd7, 1);
      launch(SEL_REMU, 32'd100, 32'd7, 1);
      launch(SEL_DIV,  32'hFFFF_FFF9, 32'd2, 1);
      launch(SEL_REM,  32'hFFFF_FFF9, 32'd2, 1);
      launch(SEL_REM,  32'd7, 32'hFFFF_FFFE, 1);
      launch(SEL_DIV,  32'h1234, 32'd0, 1);
      launch(SEL_REMU, 32'h1234, 32'd0, 1);
      launch(SEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
      launch(SEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1);
      launch(SEL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      launch(4'b1001,  32'hFFFF_FFEC, 32'd3, 1);   // div wins over remu
      launch(4'b1100,  32'd50, 32'd8, 1);          // rem wins over remu
      drain();

      // Start with no select is ignored
      launch(4'b0000, 32'd10, 32'd2, 0);
      check("nosel_ignored", {31'b0, busy}, 32'd0);

      // Start while busy is ignored
      launch(SEL_DIVU, 32'd1000, 32'd10, 1);
      repeat (5) @(posedge clk);
      #2;
      start = 1'b1; sel = SEL_DIVU; operand_a = 32'd5; operand_b = 32'd1;
      @(posedge clk);
      #2;
      start = 1'b0; sel = '0;
      drain();

      // Flush during CALC: no done, result retained
      prior = last_result;
      launch(SEL_DIVU, 32'd77, 32'd5, 0);
      repeat (9) @(posedge clk);
      #2;
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #2;
      check("flush_result_kept", result, prior);

      // start + flush together in IDLE: nothing accepted
      wait_idle();
      start = 1'b1; flush = 1'b1; sel = SEL_DIVU; operand_a = 32'd9; operand_b = 32'd2;
      @(posedge clk);
      #2;
      start = 1'b0; flush = 1'b0; sel = '0;
      check("startflush_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(posedge clk);
      #2;
      check("startflush_result_kept", result, prior);

      // Asynchronous reset mid-CALC, off the clock edge
      launch(SEL_DIVU, 32'd12345, 32'd17, 0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_zero_flag", {31'b0, zero_flag}, 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      last_result = '0;
      launch(SEL_DIVU, 32'd9, 32'd3, 1);
      drain();

      // Randomized operations, back-to-back
      for (int i = 0; i < 60; i++) begin
         rs = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) rs = 4'($urandom_range(1, 15));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(1, 16));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            4:       rb = ra;
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         launch(rs, ra, rb, 1);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
